seq_arbiter: RTL and testbench

Shares a single byte-serial sequence detector (8-bit `data`, `sent`/`ready` handshake, `match` result) between N independent byte-stream requesters. Grants the detector to one requester per burst in round-robin order. Clears the detector between bursts and routes its `match` pulses back to the owning requester. Sits between the requester-side byte sources and the one `sequencer` instance.

---
 rtl/seq_arb_pkg.sv | 16 +
 rtl/seq_rr_pick.sv | 38 +++
 rtl/seq_arbiter.sv | 114 +++++++++++
 tb/tb_seq_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_arb_pkg.sv
// rtl/seq_arb_pkg.sv - shared types and defaults for the sequencer arbiter
package seq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    typedef logic [7:0] byte_t;

    localparam int SEQ_ARB_N     = 4;
    localparam int SEQ_ARB_DRAIN = 2;

endpackage

// File: rtl/seq_rr_pick.sv
// rtl/seq_rr_pick.sv - rotating-priority picker, first request at or after ptr
module seq_rr_pick
    import seq_arb_pkg::*;
#(
    parameter int N  = SEQ_ARB_N,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          any_o,
    output logic [PW-1:0] idx_o
);

    localparam int PW1 = PW + 1;

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum;

    // Rotate so ptr_i sits at bit 0, take the lowest set bit, then map back modulo N.
    always_comb begin
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = PW'(j);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= PW1'(N)) begin
            sum = sum - PW1'(N);
        end
        idx_o = sum[PW-1:0];
    end

    assign any_o = |req_i;

endmodule

// File: rtl/seq_arbiter.sv
// rtl/seq_arbiter.sv - round-robin sharing of one sequence detector between N byte streams
module seq_arbiter
    import seq_arb_pkg::*;
#(
    parameter int N            = SEQ_ARB_N,
    parameter int DRAIN_CYCLES = SEQ_ARB_DRAIN,
    parameter int PW           = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [N-1:0]      req_valid_i,
    input  logic [N-1:0][7:0] req_data_i,
    input  logic [N-1:0]      req_last_i,
    output logic [N-1:0]      req_ready_o,
    output logic [N-1:0]      hit_o,
    output byte_t             seq_data_o,
    output logic              seq_sent_o,
    input  logic              seq_ready_i,
    input  logic              seq_match_i,
    output logic              seq_clear_o,
    output logic              busy_o,
    output logic [PW-1:0]     owner_o
);

    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [3:0]    DRAIN_W  = 4'(DRAIN_CYCLES);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0]    drain_q, drain_d;
    logic          pick_any;
    logic [PW-1:0] pick_idx;
    logic          xfer_fire;

    seq_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i (req_valid_i),
        .ptr_i (rr_ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // State, owner, rotation pointer and drain counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            drain_q  <= drain_d;
        end
    end

    // Next-state logic plus the detector- and requester-facing muxes.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        drain_d     = drain_q;
        req_ready_o = '0;
        hit_o       = '0;
        seq_data_o  = '0;
        seq_sent_o  = 1'b0;
        seq_clear_o = 1'b0;
        xfer_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                seq_clear_o = 1'b1;
                state_d     = XFER;
            end
            XFER: begin
                seq_data_o           = req_data_i[owner_q];
                seq_sent_o           = req_valid_i[owner_q];
                req_ready_o[owner_q] = seq_ready_i;
                hit_o[owner_q]       = seq_match_i;
                xfer_fire            = req_valid_i[owner_q] && seq_ready_i;
                if (xfer_fire && req_last_i[owner_q]) begin
                    drain_d = DRAIN_W;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Late matches from the detector pipeline still belong to this owner.
                hit_o[owner_q] = seq_match_i;
                if (drain_q <= 4'd1) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_seq_arbiter.sv
// tb/tb_seq_arbiter.sv - scoreboard bench for seq_arbiter with a timeline reference model
module tb_seq_arbiter;

    localparam int N     = 4;
    localparam int DRAIN = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      hit;
    logic [7:0]        seq_data;
    logic              seq_sent;
    logic              seq_ready;
    logic              seq_match;
    logic              seq_clear;
    logic              busy;
    logic [1:0]        owner;

    seq_arbiter #(
        .N            (N),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .hit_o       (hit),
        .seq_data_o  (seq_data),
        .seq_sent_o  (seq_sent),
        .seq_ready_i (seq_ready),
        .seq_match_i (seq_match),
        .seq_clear_o (seq_clear),
        .busy_o      (busy),
        .owner_o     (owner)
    );

    always #5 clk = ~clk;

    // Requester-side byte queues ({last, data}) and the scoreboard copy.
    logic [8:0] drv_q [N][$];
    logic [8:0] exp_q [N][$];
    int         grant_log [$];

    int  n_chk  = 0;
    int  n_pass = 0;
    int  cyc    = 0;
    bit  hold_valid, ready_rand, match_en, gen_en;

    // Reference model: who owns the detector and when its burst started/ended.
    bit         m_has  = 1'b0;
    logic [1:0] m_own  = '0;
    int         m_rr   = 0;
    int         m_grant = 0;
    bit         m_done = 1'b0;
    int         m_tlast = 0;

    logic         e_busy, e_clear, e_xfer, e_route, e_sent;
    logic [N-1:0] e_ready, e_hit;
    logic [7:0]   e_data;
    logic [8:0]   sb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [1:0] pick(input logic [N-1:0] v, input int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return 2'((rr + k) % N);
        end
        return 2'd0;
    endfunction

    // Monitor: derive expectations from the timeline, compare, pop the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_has  = 1'b0;
            m_rr   = 0;
            m_done = 1'b0;
        end else begin
            if (m_has && m_done && cyc > m_tlast + DRAIN) begin
                m_rr  = (int'(m_own) + 1) % N;
                m_has = 1'b0;
            end
            e_busy  = m_has && (cyc > m_grant);
            e_clear = e_busy && (cyc == m_grant + 1);
            e_xfer  = e_busy && (cyc >= m_grant + 2) && !m_done;
            e_route = e_busy && (cyc >= m_grant + 2);
            e_ready = '0;
            e_hit   = '0;
            e_sent  = 1'b0;
            e_data  = 8'h00;
            if (e_xfer) begin
                e_sent         = req_valid[m_own];
                e_ready[m_own] = seq_ready;
                e_data         = req_data[m_own];
            end
            if (e_route) e_hit[m_own] = seq_match;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("seq_clear", 32'(seq_clear), 32'(e_clear));
            chk("seq_sent", 32'(seq_sent), 32'(e_sent));
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("hit", 32'(hit), 32'(e_hit));
            chk("seq_data", 32'(seq_data), 32'(e_data));
            if (e_busy) chk("owner", 32'(owner), 32'(m_own));
            if (seq_clear) grant_log.push_back(int'(owner));
            if (e_xfer && req_valid[m_own] && seq_ready) begin
                chk("sb_has_byte", 32'(exp_q[m_own].size() != 0), 32'd1);
                if (exp_q[m_own].size() != 0) begin
                    sb = exp_q[m_own].pop_front();
                    chk("xfer_data", 32'(seq_data), 32'(sb[7:0]));
                    if (sb[8]) begin
                        m_done  = 1'b1;
                        m_tlast = cyc;
                    end
                end
            end
            if (!m_has && req_valid != '0) begin
                m_own   = pick(req_valid, m_rr);
                m_has   = 1'b1;
                m_grant = cyc;
                m_done  = 1'b0;
            end
        end
    end

    task automatic add_burst(input int i, input int len);
        logic [8:0] b;
        for (int k = 0; k < len; k++) begin
            b = {(k == len - 1), 8'($urandom)};
            drv_q[i].push_back(b);
            exp_q[i].push_back(b);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        grant_log.delete();
    endtask

    task automatic drive();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() != 0) begin
                req_valid[i] = hold_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
                {req_last[i], req_data[i]} = drv_q[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[i]  = 8'($urandom);
            end
        end
        seq_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        seq_match = match_en ? ($urandom_range(0, 5) == 0) : 1'b0;
    endtask

    task automatic cycle();
        logic [N-1:0] hs;
        logic [8:0]   tmp;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && drv_q[i].size() != 0) tmp = drv_q[i].pop_front();
        end
        if (gen_en) begin
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() == 0 && $urandom_range(0, 5) == 0) add_burst(i, $urandom_range(1, 4));
            end
        end
        drive();
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (drv_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        seq_ready = 1'b0; seq_match = 1'b0;
        hold_valid = 1'b1; ready_rand = 1'b0; match_en = 1'b0; gen_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Contention from reset: everyone requests, requester 0 twice.
        add_burst(0, 2); add_burst(1, 2); add_burst(2, 2); add_burst(3, 2); add_burst(0, 2);
        drive();
        for (int k = 0; k < 100 && grant_log.size() < 5; k++) cycle();
        chk("grant_count", 32'(grant_log.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("grant_order%0d", k), (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hffff_ffff, 32'(exp_order[k]));

        // Random traffic with backpressure, owner valid gaps and stray/late matches.
        hold_valid = 1'b0; ready_rand = 1'b1; match_en = 1'b1; gen_en = 1'b1;
        repeat (2500) cycle();

        // Quiesce, then abort requester 3's burst with reset after its 2nd byte.
        gen_en = 1'b0; match_en = 1'b0; ready_rand = 1'b0; hold_valid = 1'b1;
        for (int k = 0; k < 300 && (!queues_empty() || busy); k++) cycle();
        chk("quiesced", 32'(busy), 32'd0);
        add_burst(3, 4);
        for (int k = 0; k < 30 && drv_q[3].size() != 2; k++) cycle();
        chk("burst3_progress", 32'(drv_q[3].size()), 32'd2);
        reset = 1'b1; seq_ready = 1'b0; seq_match = 1'b0;
        flush();
        for (int i = 0; i < N; i++) add_burst(i, 1);
        cycle();
        for (int k = 0; k < 60 && grant_log.size() < 4; k++) cycle();
        chk("post_reset_grants", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("post_reset_order%0d", k), (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hffff_ffff, 32'(k));

        // Final drain: every scoreboard byte must have been consumed.
        ready_rand = 1'b1; match_en = 1'b1;
        for (int k = 0; k < 300 && (!queues_empty() || busy); k++) cycle();
        for (int i = 0; i < N; i++) chk($sformatf("sb_empty%0d", i), 32'(exp_q[i].size()), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
